stream_memory: RTL and testbench

Single-clock DATA_SIZE x DEPTH storage array with a free-running write port and a programmable strided read engine that streams a row or column of matrix operands to the multiplier datapath over a valid/ready handshake. It replaces the bare asynchronous-read array in the operand path. Reads become registered and backpressure-aware, so one start command delivers COUNT elements at BASE, BASE+STRIDE, BASE+2*STRIDE, and so on.

---
 rtl/stream_memory_if.sv | 36 +++
 rtl/stream_memory.sv | 116 +++++++++++
 tb/tb_stream_memory.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/stream_memory_if.sv
// Operand-stream bundle: write port, stream command/status and the valid/ready read beat.
// The memory side takes the slave modport; the producer/consumer takes master.
interface stream_memory_if #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        w_addr_i;
  logic [DATA_SIZE-1:0] w_data_i;
  logic                 w_en_i;
  logic                 start_i;
  logic [AW-1:0]        base_i;
  logic [AW-1:0]        stride_i;
  logic [AW:0]          count_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DATA_SIZE-1:0] r_data_o;
  logic                 r_valid_o;
  logic                 r_last_o;
  logic                 r_ready_i;

  modport slave (
    input  w_addr_i, w_data_i, w_en_i,
    input  start_i, base_i, stride_i, count_i,
    input  r_ready_i,
    output busy_o, done_o, r_data_o, r_valid_o, r_last_o
  );

  modport master (
    output w_addr_i, w_data_i, w_en_i,
    output start_i, base_i, stride_i, count_i,
    output r_ready_i,
    input  busy_o, done_o, r_data_o, r_valid_o, r_last_o
  );
endinterface

// File: rtl/stream_memory.sv
// Strided read-stream memory; write-first fetch forwarding under STREAM_MEMORY_FWD_EN (read-first otherwise).
// First beat two edges after start, then 1 beat/cycle; output register holds while r_ready_i is low.
module stream_memory #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 8
) (
  input logic             clk,
  input logic             rst,
  stream_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        addr;
  logic [AW-1:0]        stride;
  logic [AW:0]          remaining;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 busy;
  logic                 done;

  logic                 slot_free;
  logic                 fetch;
  logic                 last_hs;
  logic [DATA_SIZE-1:0] fetch_data;

  assign slot_free = !r_valid || bus.r_ready_i;
  assign fetch     = (state == RUN) && (remaining != '0) && slot_free;
  assign last_hs   = r_valid && bus.r_ready_i && r_last;

`ifdef STREAM_MEMORY_FWD_EN
  assign fetch_data = (bus.w_en_i && (bus.w_addr_i == addr)) ? bus.w_data_i : mem[addr];
`else
  assign fetch_data = mem[addr];
`endif

  // Storage is deliberately left out of reset so contents survive a stream abort.
  always_ff @(posedge clk) begin
    if (bus.w_en_i) begin
      mem[bus.w_addr_i] <= bus.w_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      stride    <= '0;
      remaining <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.count_i != '0) begin
              state     <= RUN;
              addr      <= bus.base_i;
              stride    <= bus.stride_i;
              remaining <= bus.count_i;
              busy      <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (last_hs) begin
            state   <= FIN;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (fetch) begin
            r_data    <= fetch_data;
            r_valid   <= 1'b1;
            r_last    <= (remaining == (AW+1)'(1));
            addr      <= addr + stride;
            remaining <= remaining - 1'b1;
          end else if (slot_free) begin
            r_valid <= 1'b0;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.r_data_o  = r_data;
  assign bus.r_valid_o = r_valid;
  assign bus.r_last_o  = r_last;
endmodule

// File: tb/tb_stream_memory.sv
// Directed bench for stream_memory: expected beats are queued at stream start and checked as the DUT emits them.
module tb_stream_memory;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_memory_if #(.DATA_SIZE(DW), .DEPTH(DEPTH)) bus ();

  stream_memory #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            hs_cnt;
  bit            saw_last;
  exp_t          exp_q[$];
  logic [DW-1:0] tb_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Compare any presented beat with the scoreboard head, retire it on handshake, then advance one edge.
  task automatic step();
    if (bus.r_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", bus.r_valid_o, 32'd0);
        if (bus.r_ready_i) hs_cnt++;
      end else begin
        chk("beat_data", bus.r_data_o, exp_q[0].d);
        chk("beat_last", bus.r_last_o, exp_q[0].l);
        if (bus.r_ready_i) begin
          if (exp_q[0].l) saw_last = 1'b1;
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int base, input int stride, input int count, input int coll_idx);
    exp_q.delete();
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.d = tb_mem[(base + i * stride) % DEPTH];
`ifdef STREAM_MEMORY_FWD_EN
      if (i == coll_idx) e.d = 8'hAA;
`endif
      e.l = (i == count - 1);
      exp_q.push_back(e);
    end
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic run_stream(input int base, input int stride, input int count,
                            input int mode, input int coll_idx);
    int cyc;
    int ca;
    push_expected(base, stride, count, coll_idx);
    hs_cnt   = 0;
    saw_last = 1'b0;
    bus.base_i    = 3'(base);
    bus.stride_i  = 3'(stride);
    bus.count_i   = 4'(count);
    bus.start_i   = 1'b1;
    bus.r_ready_i = (mode == 0);
    step();
    bus.start_i = 1'b0;
    if (count == 0) begin
      chk("zero_busy", bus.busy_o, 32'd0);
      chk("zero_done", bus.done_o, 32'd1);
      chk("zero_valid", bus.r_valid_o, 32'd0);
      step();
      chk("zero_done_clear", bus.done_o, 32'd0);
      chk("zero_no_beats", hs_cnt, 32'd0);
      return;
    end
    chk("start_busy", bus.busy_o, 32'd1);
    chk("start_no_valid", bus.r_valid_o, 32'd0);
    cyc = 0;
    for (int c = 0; c < 200 && !saw_last; c++) begin
      bus.r_ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      ca = (base + c * stride) % DEPTH;
      if (c == coll_idx) begin
        bus.w_en_i   = 1'b1;
        bus.w_addr_i = 3'(ca);
        bus.w_data_i = 8'hAA;
      end
      if (c == 1) begin
        bus.start_i = 1'b1;
        bus.base_i  = 3'd7;
        bus.count_i = 4'd1;
      end
      step();
      cyc++;
      bus.w_en_i  = 1'b0;
      bus.start_i = 1'b0;
      if (c == coll_idx) tb_mem[ca] = 8'hAA;
      if (mode == 0 && c == 0) chk("first_beat_latency", bus.r_valid_o, 32'd1);
    end
    chk("stream_complete", saw_last, 32'd1);
    chk("handshake_count", hs_cnt, count);
    if (mode == 0) chk("stream_cycles", cyc, count + 1);
    chk("end_valid", bus.r_valid_o, 32'd0);
    chk("end_busy", bus.busy_o, 32'd0);
    chk("end_done", bus.done_o, 32'd1);
    bus.r_ready_i = 1'b0;
    step();
    chk("done_one_cycle", bus.done_o, 32'd0);
    chk("idle_busy", bus.busy_o, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.w_addr_i  = '0;
    bus.w_data_i  = '0;
    bus.w_en_i    = 1'b0;
    bus.start_i   = 1'b0;
    bus.base_i    = '0;
    bus.stride_i  = '0;
    bus.count_i   = '0;
    bus.r_ready_i = 1'b0;
    hs_cnt        = 0;
    saw_last      = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy_o, 32'd0);
    chk("rst_done", bus.done_o, 32'd0);
    chk("rst_valid", bus.r_valid_o, 32'd0);
    chk("rst_last", bus.r_last_o, 32'd0);
    chk("rst_data", bus.r_data_o, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      bus.w_en_i   = 1'b1;
      bus.w_addr_i = 3'(i);
      bus.w_data_i = 8'(i + 8'h10);
      tb_mem[i]    = 8'(i + 8'h10);
      step();
    end
    bus.w_en_i = 1'b0;
    step();

    run_stream(2, 1, 4, 0, -1);   // contiguous row
    run_stream(6, 3, 5, 0, -1);   // strided with wrap
    run_stream(2, 1, 4, 1, -1);   // backpressure
    run_stream(5, 0, 3, 0, -1);   // stride 0 repeats
    run_stream(1, 1, 8, 0, -1);   // full-depth count
    run_stream(0, 1, 4, 0, 2);    // write collides with fetch of element 2
    run_stream(3, 1, 0, 0, -1);   // empty stream

    // Abort an 8-element stream after its second handshake.
    push_expected(0, 1, 8, -1);
    hs_cnt        = 0;
    saw_last      = 1'b0;
    bus.base_i    = 3'd0;
    bus.stride_i  = 3'd1;
    bus.count_i   = 4'd8;
    bus.start_i   = 1'b1;
    bus.r_ready_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int c = 0; c < 50 && hs_cnt < 2; c++) step();
    chk("abort_two_beats", hs_cnt, 32'd2);
    bus.r_ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("abort_busy", bus.busy_o, 32'd0);
    chk("abort_valid", bus.r_valid_o, 32'd0);
    chk("abort_done", bus.done_o, 32'd0);
    step();
    chk("abort_no_done", bus.done_o, 32'd0);

    run_stream(0, 1, 8, 0, -1);   // memory survived reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
